// File: rtl/shared_ram_arb_pkg.sv
// Shared work RAM arbiter: common types.
// FSM encoding and port identifiers.
package shared_ram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_CAP  = 2'd2
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // Pending-port pick; on a tie the port not served last wins.
  function automatic logic pick_port(
    input logic pa,
    input logic pb,
    input logic last
  );
    if (pa && pb) return (last == PORT_A) ? PORT_B : PORT_A;
    return pa ? PORT_A : PORT_B;
  endfunction

endpackage

// File: rtl/shared_ram_arb_port.sv
// Per-requester state: served flag, pending
// and the stable read-data latch.
module shared_ram_arb_port #(
  parameter int DW = 8
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          req,
  input  logic          cap,
  input  logic          rd_cap,
  input  logic [DW-1:0] ram_q,
  output logic          pend,
  output logic [DW-1:0] rdata
);

  logic served;

  assign pend = req & ~served;

  // Served once per held request; a dropped request re-arms.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      served <= 1'b0;
    end else if (!req) begin
      served <= 1'b0;
    end else if (cap) begin
      served <= 1'b1;
    end
  end

  // Read data only changes on a captured read for this port.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= '0;
    end else if (rd_cap) begin
      rdata <= ram_q;
    end
  end

endmodule

// File: rtl/shared_ram_arb.sv
// Two-port arbiter sharing one sync RAM
// between the main CPU (A) and sub CPU (B).
module shared_ram_arb
  import shared_ram_arb_pkg::*;
#(
  parameter int AW = 11,
  parameter int DW = 8
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic [DW-1:0] a_rdata,
  output logic          a_wait,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic [DW-1:0] b_rdata,
  output logic          b_wait,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_q
);

  state_t        state;
  state_t        state_nx;
  logic          grant;
  logic          op_we;
  logic          last_grant;
  logic          pend_a;
  logic          pend_b;
  logic          win;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;
  logic          cap_a;
  logic          cap_b;

  assign a_wait = pend_a;
  assign b_wait = pend_b;

  assign win       = pick_port(pend_a, pend_b, last_grant);
  assign win_we    = (win == PORT_A) ? a_we    : b_we;
  assign win_addr  = (win == PORT_A) ? a_addr  : b_addr;
  assign win_wdata = (win == PORT_A) ? a_wdata : b_wdata;

  assign cap_a = (state == ST_CAP) && (grant == PORT_A);
  assign cap_b = (state == ST_CAP) && (grant == PORT_B);

  shared_ram_arb_port #(.DW(DW)) u_port_a (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .req     (a_req),
    .cap     (cap_a),
    .rd_cap  (cap_a & ~op_we),
    .ram_q   (ram_q),
    .pend    (pend_a),
    .rdata   (a_rdata)
  );

  shared_ram_arb_port #(.DW(DW)) u_port_b (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .req     (b_req),
    .cap     (cap_b),
    .rd_cap  (cap_b & ~op_we),
    .ram_q   (ram_q),
    .pend    (pend_b),
    .rdata   (b_rdata)
  );

  // State register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state: grant, one strobe cycle, one capture cycle.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (pend_a | pend_b) state_nx = ST_ACC;
      ST_ACC:  state_nx = ST_CAP;
      ST_CAP:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // RAM command registers, loaded only when granting in IDLE.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      op_we      <= 1'b0;
      grant      <= PORT_A;
      last_grant <= PORT_B;
    end else begin
      ram_we <= 1'b0;
      if (state == ST_IDLE && (pend_a | pend_b)) begin
        ram_we     <= win_we;
        ram_addr   <= win_addr;
        ram_wdata  <= win_wdata;
        op_we      <= win_we;
        grant      <= win;
        last_grant <= win;
      end
    end
  end

endmodule

// File: tb/tb_shared_ram_arb.sv
// Scoreboard bench for shared_ram_arb.
// Sync RAM model, directed access scenarios.
module tb_shared_ram_arb;

  typedef struct {
    logic [7:0] rd;
    int         cyc;
  } exp_t;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [10:0] a_addr = '0;
  logic [7:0]  a_wdata = '0;
  logic [7:0]  a_rdata;
  logic        a_wait;
  logic        b_req = 1'b0, b_we = 1'b0;
  logic [10:0] b_addr = '0;
  logic [7:0]  b_wdata = '0;
  logic [7:0]  b_rdata;
  logic        b_wait;
  logic [10:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_q;

  logic [7:0]  mem [2048];
  logic        pl_en = 1'b0;
  logic [10:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  int we_cnt = 0;
  int we_long = 0;
  logic        prev_we = 1'b0;
  logic [10:0] we_addr = '0;
  logic [7:0]  we_data = '0;
  exp_t qa[$];
  exp_t qb[$];
  logic [7:0] la = 8'h00;
  logic [7:0] lb = 8'h00;
  int w0;

  shared_ram_arb dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_rdata   (a_rdata),
    .a_wait    (a_wait),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_rdata   (b_rdata),
    .b_wait    (b_wait),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_q     (ram_q)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Single-port sync RAM with a bench preload port.
  always @(posedge clk_sys) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_q <= mem[ram_addr];
  end

  // Strobe counter and width watch.
  always @(negedge clk_sys) begin
    if (ram_we) begin
      we_cnt  <= we_cnt + 1;
      we_addr <= ram_addr;
      we_data <= ram_wdata;
      if (prev_we) we_long <= we_long + 1;
    end
    prev_we <= ram_we;
  end

  task automatic check(input string nm, input int act, input int ex);
    n_vec++;
    if (act != ex) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, ex);
    end
  endtask

  // Monitor: a release is wait falling while req is held.
  initial begin : monitor
    logic wa, wb;
    exp_t e;
    wa = 1'b0;
    wb = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (!a_req) wa = 1'b0;
      else if (a_wait) wa = 1'b1;
      else if (wa) begin
        wa = 1'b0;
        if (qa.size() == 0) check("a_unexpected_release", cyc, -1);
        else begin
          e = qa.pop_front();
          check("a_rdata", a_rdata, e.rd);
          check("a_release_cycle", cyc, e.cyc);
        end
      end
      if (!b_req) wb = 1'b0;
      else if (b_wait) wb = 1'b1;
      else if (wb) begin
        wb = 1'b0;
        if (qb.size() == 0) check("b_unexpected_release", cyc, -1);
        else begin
          e = qb.pop_front();
          check("b_rdata", b_rdata, e.rd);
          check("b_release_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic preload(input logic [10:0] ad, input logic [7:0] d);
    pl_en = 1'b1;
    pl_addr = ad;
    pl_data = d;
    step(1);
    pl_en = 1'b0;
  endtask

  task automatic go_a(input logic we, input logic [10:0] ad,
                      input logic [7:0] wd, input logic [7:0] erd,
                      input int dly);
    a_we = we;
    a_addr = ad;
    a_wdata = wd;
    a_req = 1'b1;
    qa.push_back('{rd: erd, cyc: cyc + dly});
  endtask

  task automatic go_b(input logic we, input logic [10:0] ad,
                      input logic [7:0] wd, input logic [7:0] erd,
                      input int dly);
    b_we = we;
    b_addr = ad;
    b_wdata = wd;
    b_req = 1'b1;
    qb.push_back('{rd: erd, cyc: cyc + dly});
  endtask

  initial begin
    #1;
    check("rst_a_wait", a_wait, 0);
    check("rst_b_wait", b_wait, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_a_rdata", a_rdata, 0);
    check("rst_b_rdata", b_rdata, 0);
    preload(11'h123, 8'h5A);
    preload(11'h010, 8'h11);
    preload(11'h020, 8'h22);
    preload(11'h030, 8'h33);
    preload(11'h040, 8'h44);
    preload(11'h050, 8'h55);
    preload(11'h300, 8'h3A);
    reset_n = 1'b1;
    step(2);

    // Single A read.
    w0 = we_cnt;
    go_a(1'b0, 11'h123, 8'h00, 8'h5A, 3);
    la = 8'h5A;
    step(4);
    a_req = 1'b0;
    check("a_read_no_strobe", we_cnt - w0, 0);
    step(2);

    // Single B write, then read back.
    w0 = we_cnt;
    go_b(1'b1, 11'h7FF, 8'hC3, lb, 3);
    step(4);
    b_req = 1'b0;
    check("b_write_strobes", we_cnt - w0, 1);
    check("b_write_addr", we_addr, 11'h7FF);
    check("b_write_data", we_data, 8'hC3);
    step(1);
    go_b(1'b0, 11'h7FF, 8'h00, 8'hC3, 3);
    lb = 8'hC3;
    step(4);
    b_req = 1'b0;
    step(2);

    // Tie with last grant B: A first.
    go_a(1'b0, 11'h010, 8'h00, 8'h11, 3);
    go_b(1'b0, 11'h020, 8'h00, 8'h22, 6);
    la = 8'h11;
    lb = 8'h22;
    step(4);
    a_req = 1'b0;
    step(3);
    b_req = 1'b0;
    step(2);

    // Lone A access, then a tie: B first.
    go_a(1'b0, 11'h030, 8'h00, 8'h33, 3);
    step(4);
    a_req = 1'b0;
    step(1);
    go_a(1'b0, 11'h040, 8'h00, 8'h44, 6);
    go_b(1'b0, 11'h050, 8'h00, 8'h55, 3);
    la = 8'h44;
    lb = 8'h55;
    step(4);
    b_req = 1'b0;
    step(3);
    a_req = 1'b0;
    step(2);

    // Held write: one access only; re-arm after a gap.
    w0 = we_cnt;
    go_a(1'b1, 11'h100, 8'h9C, la, 3);
    step(13);
    check("held_one_strobe", we_cnt - w0, 1);
    check("held_mem", mem[11'h100], 8'h9C);
    a_req = 1'b0;
    step(1);
    go_a(1'b1, 11'h101, 8'h9D, la, 3);
    step(4);
    a_req = 1'b0;
    check("rearm_strobes", we_cnt - w0, 2);
    check("rearm_mem", mem[11'h101], 8'h9D);
    step(2);

    // Abort B write in ACC.
    w0 = we_cnt;
    b_we = 1'b1;
    b_addr = 11'h055;
    b_wdata = 8'h11;
    b_req = 1'b1;
    step(1);
    b_req = 1'b0;
    step(4);
    check("abort_strobes", we_cnt - w0, 1);
    check("abort_mem", mem[11'h055], 8'h11);
    check("abort_b_wait", b_wait, 0);
    go_b(1'b0, 11'h055, 8'h00, 8'h11, 3);
    lb = 8'h11;
    #1;
    check("abort_fresh_wait", b_wait, 1);
    step(4);
    b_req = 1'b0;
    step(2);

    // Async reset during an A write strobe.
    a_we = 1'b1;
    a_addr = 11'h200;
    a_wdata = 8'h77;
    a_req = 1'b1;
    step(1);
    check("pre_reset_we", ram_we, 1);
    #1;
    reset_n = 1'b0;
    #1;
    check("reset_we_async", ram_we, 0);
    check("reset_a_rdata", a_rdata, 0);
    check("reset_b_rdata", b_rdata, 0);
    check("reset_a_wait", a_wait, 1);
    b_we = 1'b0;
    b_addr = 11'h300;
    b_req = 1'b1;
    step(1);
    reset_n = 1'b1;
    la = 8'h00;
    qa.push_back('{rd: la, cyc: cyc + 3});
    qb.push_back('{rd: 8'h3A, cyc: cyc + 6});
    step(4);
    a_req = 1'b0;
    step(3);
    b_req = 1'b0;
    check("post_reset_mem", mem[11'h200], 8'h77);
    step(3);

    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);
    check("strobe_width", we_long, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shared_ram_arb.md
Name: shared_ram_arb

Overview:
Two-port arbiter that shares one single-port sync RAM (shared work RAM, 8-bit) between the main CPU bus (port A) and the sub/sound CPU bus (port B). Each requester sees a wait output that holds its CPU until the access is serviced, and a stable read-data latch. Sits between the CPU wrappers' bus outputs (rd/wr/mreq/ab/dout, wait input) and the dual-clocked-free BRAM on clk_sys.

Parameters:
AW, 11, RAM address width (2 KB shared RAM)
DW, 8, data width

Ports:
clk_sys  in  1  system clock; all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
a_req  in  1  port A access request (decoded chip-select & (rd|wr)), level, held until wait released and CPU ends cycle
a_we  in  1  port A write (1) / read (0), valid with a_req
a_addr  in  AW  port A address
a_wdata  in  DW  port A write data
a_rdata  out  DW  port A read-data latch
a_wait  out  1  port A wait (active high)
b_req, b_we, b_addr, b_wdata, b_rdata, b_wait: same for port B
ram_addr  out  AW  RAM address
ram_wdata  out  DW  RAM write data
ram_we  out  1  RAM write strobe, one clk_sys cycle
ram_q  in  DW  RAM read data, valid 1 cycle after ram_addr

Behaviour:
- Reset (async, reset_n=0): state IDLE; ram_we=0; ram_addr=0; ram_wdata=0; a_rdata=b_rdata=0; served_a=served_b=0; last_grant=B (so A wins first tie). a_wait/b_wait follow the combinational rule below, so they read 0 unless a requester is requesting.
- pend_x = x_req & ~served_x. x_wait = pend_x (combinational, no register delay, so the CPU sees wait in the same cycle it asserts req).
- served_x is set at CAP for the granted port. It clears on any cycle with x_req=0. A held request is serviced exactly once.
- FSM, 3 states:
  - IDLE: if pend_a|pend_b, choose winner: if only one pending, that one; if both, the port != last_grant. Register ram_addr/ram_wdata/op/grant from the winner; ram_we <= winner_we; last_grant <= winner; go ACC. Else stay.
  - ACC: ram_we <= 0 (write strobe exactly 1 cycle); address held; go CAP.
  - CAP: ram_q valid; if op=read, rdata of granted port <= ram_q; if granted port's req still 1, served <= 1; go IDLE.
- Latency: req rises in cycle 0 with bus idle -> ram_we/addr in cycle 1, capture at end of cycle 2, wait low from cycle 3. Minimum 3 cycles per access; back-to-back alternating grants give 3-cycle slots.
- x_rdata holds its value until the next read by that port. Writes never change rdata.
- Simultaneous A/B requests: strict alternation via last_grant. The loser keeps wait high; it is never starved beyond one access.
- Same-address A write / B read in the same cycle: serialized by grant order. The read returns the post-write value only if the write was granted first.
- Request dropped mid-access (req=0 in ACC/CAP): the RAM write still completes if already strobed. The read still captures into rdata. served is not set. FSM returns to IDLE normally.
- Reset asserted mid-access: immediate return to IDLE; ram_we forced 0 asynchronously. A partial write is impossible because the strobe is a single registered cycle.
- Address and wdata are sampled only in IDLE. Changes while granted are ignored.

Decomposition:
- Shared package: state encoding (ST_IDLE, ST_ACC, ST_CAP) and port-id constants (PORT_A=0, PORT_B=1).
- No sub-module needed. Optional per-port helper shared_ram_port (pend/served/rdata latch), instantiated twice.

Test Plan:
- Single A read: preload RAM[0x123]=0x5A, a_req=1, a_we=0, a_addr=0x123 -> a_wait=1 for cycles 0-2, a_rdata=0x5A and a_wait=0 at cycle 3; ram_we never 1.
- Single B write: b_addr=0x7FF, b_wdata=0xC3, b_we=1 -> ram_we high exactly one cycle with ram_addr=0x7FF and ram_wdata=0xC3; b_wait drops at cycle 3. A subsequent B read of 0x7FF returns 0xC3.
- Simultaneous after reset: A read 0x010, B read 0x020 in same cycle -> A granted first (released cycle 3), B released cycle 6. Repeat the tie: B granted first.
- Held request: a_req held 10 cycles after release -> exactly one RAM access, no re-grant. Drop a_req one cycle, reassert -> a new access.
- Abort: B write 0x055=0x11, drop b_req in ACC -> RAM[0x055]=0x11 and served_b stays 0. Reasserting b_req starts a fresh access.
- Async reset in ACC during an A write -> ram_we=0 immediately. After release, FSM is in IDLE with all rdata=0 and a pending request re-arbitrated with A priority.
